pipe_ctrl: RTL

Pipeline control unit for the five-stage core. It gathers stall requests from the IF, ID, EX and MEM stages and exception/ERET indications from MEM. It drives the per-stage stall vector and the flush strobe to every pipeline buffer, including IF/ID, and supplies the redirect PC to the PC register. It also runs a post-flush recovery state, a stall watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_wdog.sv | 43 ++++
 rtl/pipe_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline control unit: stall vector width,
//   the four stall codes, the ERET excepttype code, the FSM state encoding
//   and the default exception entry address.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    // Stall vector bit order is {wb, mem, ex, id, if, pc}
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_ERET        = 32'h0000_000e;
    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_0020;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    // The deepest requesting stage wins: it must hold itself and everything
    // upstream of it.
    function automatic logic [STALL_W-1:0] stall_code(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog
//   Stall watchdog: counts consecutive stalled cycles and raises a sticky
//   flag once the count reaches WDOG_MAX.
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous reset, active low
//   stall_active stall vector is nonzero this cycle
//   flush        pipeline flush this cycle
//   trip_o       sticky watchdog flag, cleared only by reset
module pipe_ctrl_wdog #(
    parameter int WDOG_MAX = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    input  logic flush,
    output logic trip_o
);

    // The flag must already read 1 after the edge on which the count
    // reaches WDOG_MAX, so it is set alongside the final increment.
    localparam logic [10:0] WDOG_LAST = 11'(WDOG_MAX - 1);

    logic [10:0] cnt;

    // Once tripped the counter is frozen; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            trip_o <= 1'b0;
        end else if (!trip_o) begin
            if (flush || !stall_active) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 11'd1;
                if (cnt == WDOG_LAST) begin
                    trip_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline control unit for the five-stage core. Merges stage stall
//   requests and MEM-stage exception/ERET indications into the per-stage
//   stall vector, the flush strobe and the redirect PC. A one-cycle RECOVER
//   state masks the flushed MEM slot after a redirect.
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous reset, active low
//   stallreq_if  fetch bus not ready
//   stallreq_id  load-use hazard
//   stallreq_ex  multi-cycle mult/div in progress
//   stallreq_mem data bus not ready
//   excepttype_i MEM exception code: 0 none, 0xe ERET, other exception
//   cp0_epc_i    return address for ERET
//   stall_o      {wb, mem, ex, id, if, pc} hold vector
//   flush_o      clear all pipeline buffers this cycle
//   new_pc_o     redirect target, valid with flush_o
//   wdog_trip_o  sticky watchdog flag
//   stall_cnt_o  saturating count of stalled cycles
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          WDOG_MAX = 1024,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic [31:0]        excepttype_i,
    input  logic [31:0]        cp0_epc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic [31:0]        new_pc_o,
    output logic               wdog_trip_o,
    output logic [31:0]        stall_cnt_o
);

    state_t state;
    logic   take_exc;

    // In RECOVER the MEM slot is a flushed bubble, so its excepttype is stale.
    assign take_exc = (state == ST_RUN) && (excepttype_i != 32'd0);

    // Outputs are combinational so a hazard stalls in the cycle it is seen.
    // Reset is folded in so the outputs drop the moment rst goes low.
    always_comb begin
        stall_o  = STALL_NONE;
        flush_o  = 1'b0;
        new_pc_o = 32'd0;
        if (rst) begin
            if (take_exc) begin
                flush_o  = 1'b1;
                new_pc_o = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VEC;
            end else begin
                stall_o = stall_code(stallreq_if, stallreq_id,
                                     stallreq_ex, stallreq_mem);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= take_exc ? ST_RECOVER : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= 32'd0;
        end else if ((stall_o != STALL_NONE) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

    pipe_ctrl_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall_o != STALL_NONE),
        .flush        (flush_o),
        .trip_o       (wdog_trip_o)
    );

endmodule
